// File: rtl/bp_fe_ltb_ctrl.sv
// bp_fe_ltb_ctrl: LTB memory sequencer; clears the table after reset, then arbitrates
// prediction reads against a small FIFO of resolved-branch updates on one memory port.
module bp_fe_ltb_ctrl #(
    parameter int els_p = 64,
    parameter int vaddr_width_p = 39,
    parameter int entry_width_p = 32,
    parameter int wq_els_p = 2,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_li,
    input  logic                     r_v_i,
    input  logic [vaddr_width_p-1:0] r_addr_i,
    output logic                     r_ready_o,
    output logic                     r_hazard_o,
    input  logic                     w_v_i,
    input  logic [vaddr_width_p-1:0] w_addr_i,
    input  logic [entry_width_p-1:0] w_data_i,
    output logic                     w_ready_o,
    output logic                     mem_v_o,
    output logic                     mem_w_o,
    output logic [lg_els_lp-1:0]     mem_addr_o,
    output logic [entry_width_p-1:0] mem_data_o,
    output logic                     init_done_o
);
    localparam int ptr_w_lp = (wq_els_p > 1) ? $clog2(wq_els_p) : 1;
    localparam int cnt_w_lp = $clog2(wq_els_p) + 1;
    localparam logic [lg_els_lp-1:0] last_idx_lp = lg_els_lp'(els_p - 1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(wq_els_p - 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(wq_els_p);

    typedef enum logic {INIT, RUN} state_e;
    state_e state;
    logic [lg_els_lp-1:0] init_idx, r_idx, w_idx;
    logic [lg_els_lp-1:0] q_idx [wq_els_p];
    logic [entry_width_p-1:0] q_data [wq_els_p];
    logic [wq_els_p-1:0] q_v;
    logic [ptr_w_lp-1:0] rd_ptr, wr_ptr;
    logic [cnt_w_lp-1:0] cnt;
    logic init_s, run, full, empty, drain, rd, enq, hit, unused;

    assign r_idx = r_addr_i[lg_els_lp+1:2];
    assign w_idx = w_addr_i[lg_els_lp+1:2];
    assign unused = ^{r_addr_i[vaddr_width_p-1:lg_els_lp+2], r_addr_i[1:0],
                      w_addr_i[vaddr_width_p-1:lg_els_lp+2], w_addr_i[1:0]};

    // state is forced to INIT by reset, so the sweep outputs are gated to stay silent in reset
    assign init_s = reset_li & (state == INIT);
    assign run = state == RUN;
    assign full = cnt == full_cnt_lp;
    assign empty = cnt == '0;
    assign drain = run & ~empty & (full | ~r_v_i);
    assign rd = run & ~full & r_v_i;
    assign w_ready_o = run & ~full;
    assign enq = w_v_i & w_ready_o;
    assign r_ready_o = rd;
    assign mem_v_o = init_s | drain | rd;
    assign mem_w_o = init_s | drain;
    assign mem_addr_o = init_s ? init_idx : drain ? q_idx[rd_ptr] : rd ? r_idx : '0;
    assign mem_data_o = drain ? q_data[rd_ptr] : '0;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < wq_els_p; i++) hit = hit | (q_v[i] & (q_idx[i] == r_idx));
    end

    always_ff @(posedge clk_i)
        if (enq) begin
            q_idx[wr_ptr] <= w_idx;
            q_data[wr_ptr] <= w_data_i;
        end

    always_ff @(posedge clk_i or negedge reset_li)
        if (!reset_li) begin
            state <= INIT;
            init_idx <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt <= '0;
            q_v <= '0;
            r_hazard_o <= 1'b0;
            init_done_o <= 1'b0;
        end else begin
            if (state == INIT) begin
                init_idx <= init_idx + 1'b1;
                if (init_idx == last_idx_lp) begin
                    state <= RUN;
                    init_done_o <= 1'b1;
                end
            end
            if (drain) rd_ptr <= (rd_ptr == last_ptr_lp) ? '0 : rd_ptr + 1'b1;
            if (enq) wr_ptr <= (wr_ptr == last_ptr_lp) ? '0 : wr_ptr + 1'b1;
            for (int i = 0; i < wq_els_p; i++)
                q_v[i] <= (q_v[i] & ~(drain & (rd_ptr == ptr_w_lp'(i)))) | (enq & (wr_ptr == ptr_w_lp'(i)));
            cnt <= cnt + cnt_w_lp'(enq) - cnt_w_lp'(drain);
            r_hazard_o <= rd & hit;
        end
endmodule

// File: tb/tb_bp_fe_ltb_ctrl.sv
// tb_bp_fe_ltb_ctrl: directed bench for bp_fe_ltb_ctrl with default parameters
// (64 entries, 39-bit addresses, 32-bit entries, 2-deep write queue).
module tb_bp_fe_ltb_ctrl;
    logic clk_i = 1'b0, reset_li = 1'b0;
    logic r_v_i = 1'b0, w_v_i = 1'b0;
    logic [38:0] r_addr_i = '0, w_addr_i = '0;
    logic [31:0] w_data_i = '0;
    logic r_ready_o, r_hazard_o, w_ready_o, mem_v_o, mem_w_o, init_done_o;
    logic [5:0] mem_addr_o;
    logic [31:0] mem_data_o;
    int total = 0, bad = 0;

    always #5 clk_i = ~clk_i;

    bp_fe_ltb_ctrl dut (
        .clk_i(clk_i), .reset_li(reset_li),
        .r_v_i(r_v_i), .r_addr_i(r_addr_i), .r_ready_o(r_ready_o), .r_hazard_o(r_hazard_o),
        .w_v_i(w_v_i), .w_addr_i(w_addr_i), .w_data_i(w_data_i), .w_ready_o(w_ready_o),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .init_done_o(init_done_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag, input logic v, input logic w, input logic [5:0] a, input logic [31:0] d);
        chk(tag, 64'({mem_v_o, mem_w_o, mem_addr_o, mem_data_o}), 64'({v, w, a, d}));
    endtask

    task automatic zero(input string tag);
        chk(tag, 64'({r_ready_o, r_hazard_o, w_ready_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, init_done_o}), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2 zero("rst_hold0");
        tick();
        tick();
        zero("rst_hold");
        // requests held high during the sweep must be refused and never enqueued
        reset_li = 1'b1; r_v_i = 1'b1; w_v_i = 1'b1; w_addr_i = 39'h80000010;
        for (int i = 0; i < 64; i++) begin
            #2 chk("init_sweep", 64'({mem_v_o, mem_w_o, mem_addr_o, mem_data_o, r_ready_o, w_ready_o, init_done_o}),
                   64'({1'b1, 1'b1, 6'(i), 32'h0, 3'b000}));
            tick();
        end
        r_v_i = 1'b0; w_v_i = 1'b0;
        #2 chk("init_done", init_done_o, 1); chk("run_w_ready", w_ready_o, 1); chk_mem("run_idle", 0, 0, 0, 0);
        tick();

        r_v_i = 1'b1; r_addr_i = 39'h80000200; w_v_i = 1'b1; w_addr_i = 39'h80000130; w_data_i = 32'hA5A50001;
        #2 chk_mem("rd_a", 1, 0, 6'h00, 0); chk("r_ready_a", r_ready_o, 1);
        tick();
        w_v_i = 1'b0; r_addr_i = 39'h80000104;
        #2 chk_mem("rd_b", 1, 0, 6'h01, 0); chk("hazard_b", r_hazard_o, 0);
        tick();
        r_addr_i = 39'h80000108;
        #2 chk_mem("rd_c", 1, 0, 6'h02, 0); chk("r_ready_c", r_ready_o, 1);
        tick();
        r_v_i = 1'b0;
        #2 chk_mem("drain_d", 1, 1, 6'h0c, 32'hA5A50001); chk("r_ready_d", r_ready_o, 0);
        tick();
        #2 chk_mem("idle_e", 0, 0, 0, 0);
        tick();

        w_v_i = 1'b1; w_addr_i = 39'h80000130; w_data_i = 32'h11;
        #2 chk_mem("no_bypass_f", 0, 0, 0, 0);
        tick();
        w_v_i = 1'b0; r_v_i = 1'b1; r_addr_i = 39'h80000130;
        #2 chk_mem("rd_hit_g", 1, 0, 6'h0c, 0);
        tick();
        r_addr_i = 39'h80000134;
        #2 chk("hazard_h", r_hazard_o, 1); chk_mem("rd_miss_h", 1, 0, 6'h0d, 0);
        tick();
        r_v_i = 1'b0;
        #2 chk("hazard_i", r_hazard_o, 0); chk_mem("drain_i", 1, 1, 6'h0c, 32'h11);
        tick();
        #2 chk("hazard_j", r_hazard_o, 0); chk_mem("idle_j", 0, 0, 0, 0);
        tick();

        r_v_i = 1'b1; r_addr_i = 39'h80000000; w_v_i = 1'b1; w_addr_i = 39'h80000010; w_data_i = 32'h22;
        #2 chk("w_ready_k", w_ready_o, 1); chk_mem("rd_k", 1, 0, 0, 0);
        tick();
        w_addr_i = 39'h80000020; w_data_i = 32'h33;
        #2 chk("w_ready_l", w_ready_o, 1); chk("r_ready_l", r_ready_o, 1);
        tick();
        // queue full: this write must be refused
        w_addr_i = 39'h80000040; w_data_i = 32'h99;
        #2 chk("w_ready_full", w_ready_o, 0); chk("r_ready_full", r_ready_o, 0); chk_mem("drain_full", 1, 1, 6'h04, 32'h22);
        tick();
        w_v_i = 1'b0;
        #2 chk("w_ready_n", w_ready_o, 1); chk("r_ready_n", r_ready_o, 1); chk("hazard_n", r_hazard_o, 0);
        chk_mem("rd_n", 1, 0, 0, 0);
        tick();
        r_v_i = 1'b0; w_v_i = 1'b1; w_addr_i = 39'h80000030; w_data_i = 32'h44;
        #2 chk("w_ready_swap", w_ready_o, 1); chk_mem("swap_drain_o", 1, 1, 6'h08, 32'h33);
        tick();
        w_v_i = 1'b0;
        #2 chk_mem("wrap_drain_p", 1, 1, 6'h0c, 32'h44);
        tick();
        #2 chk_mem("empty_q", 0, 0, 0, 0);
        tick();

        w_v_i = 1'b1; w_addr_i = 39'h80000050; w_data_i = 32'h55;
        tick();
        w_v_i = 1'b0;
        #2 reset_li = 1'b0;
        #1 zero("rst_run");
        tick();
        reset_li = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #2 chk_mem("resweep", 1, 1, 6'(i), 0);
            tick();
        end
        #2 chk_mem("idx20", 1, 1, 6'd20, 0);
        reset_li = 1'b0;
        #1 zero("rst_init");
        tick();
        reset_li = 1'b1;
        #2 chk_mem("restart0", 1, 1, 6'd0, 0);
        tick();
        repeat (63) tick();
        #2 chk("init_done2", init_done_o, 1); chk_mem("discarded", 0, 0, 0, 0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
